// File: rtl/rand_pkg.sv
// Shared types and constants for the random-draw controller and its datapath.
package rand_pkg;

  localparam int LFSR_W = 6;
  localparam int RES_W  = 2;
  localparam int CNT3_W = 3;

  // The all-zero LFSR state locks up, so a zero seed request is replaced with this.
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 6'b000001;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/rand_dp.sv
// 6-bit LFSR datapath: load, plain shift, or xor-step (x^6+x^5+1), with a 3-bit step counter.
module rand_dp (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       shift_en,
  input  logic                       xor_en,
  input  logic [rand_pkg::LFSR_W-1:0] data_in,
  output logic [rand_pkg::RES_W-1:0]  result,
  output logic [rand_pkg::CNT3_W-1:0] count
);
  import rand_pkg::*;

  logic [LFSR_W-1:0] s;

  assign result = s[LFSR_W-1:LFSR_W-RES_W];

  // xor_en takes priority over shift_en when both are asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s     <= '0;
      count <= '0;
    end else if (load) begin
      s     <= data_in;
      count <= '0;
    end else if (xor_en) begin
      s     <= {s[LFSR_W-2:0], s[5] ^ s[4]};
      count <= count + CNT3_W'(1);
    end else if (shift_en) begin
      s     <= {s[LFSR_W-2:0], 1'b0};
      count <= count + CNT3_W'(1);
    end
  end

endmodule

// File: rtl/rand_step_cnt.sv
// Loadable down-counter with zero flag; used for step counting and draw counting.
module rand_step_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/rand_top.sv
// Controller plus LFSR datapath, wired together as a single verification target.
module rand_top #(
  parameter int DRAW_STEPS = 2,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [rand_pkg::LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]            num_draws,
  input  logic                        out_ready,
`ifdef RAND_CTRL_ABORT_EN
  input  logic                        abort,
`endif
  output logic                        rnd_valid,
  output logic [rand_pkg::RES_W-1:0]  rnd_data,
  output logic                        busy,
  output logic                        done
);
  import rand_pkg::*;

  logic              dp_load, dp_shift_en, dp_xor_en;
  logic [LFSR_W-1:0] dp_data;
  logic [RES_W-1:0]  dp_result;
  logic [CNT3_W-1:0] dp_count;

  rand_ctrl #(.DRAW_STEPS(DRAW_STEPS), .CNT_W(CNT_W)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .num_draws   (num_draws),
    .out_ready   (out_ready),
`ifdef RAND_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .dp_result   (dp_result),
    .dp_count    (dp_count),
    .dp_load     (dp_load),
    .dp_shift_en (dp_shift_en),
    .dp_xor_en   (dp_xor_en),
    .dp_data     (dp_data),
    .rnd_valid   (rnd_valid),
    .rnd_data    (rnd_data),
    .busy        (busy),
    .done        (done)
  );

  rand_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .shift_en (dp_shift_en),
    .xor_en   (dp_xor_en),
    .data_in  (dp_data),
    .result   (dp_result),
    .count    (dp_count)
  );

endmodule

// File: rtl/rand_ctrl.sv
// Sequencer for the LFSR datapath: seeds it, steps it DRAW_STEPS times per draw and
// hands out 2-bit draws over valid/ready. Optional abort input under RAND_CTRL_ABORT_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | seed pushed into datapath
//   STEP  | datapath xor-stepping, DRAW_STEPS cycles
//   EMIT  | draw presented, waiting for out_ready
//   DONE  | one-cycle done pulse
module rand_ctrl #(
  parameter int                             DRAW_STEPS   = 2,
  parameter int                             CNT_W        = 8,
  parameter logic [rand_pkg::LFSR_W-1:0]    DEFAULT_SEED = rand_pkg::DEFAULT_SEED
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [rand_pkg::LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]            num_draws,
  input  logic                        out_ready,
`ifdef RAND_CTRL_ABORT_EN
  input  logic                        abort,
`endif
  input  logic [rand_pkg::RES_W-1:0]  dp_result,
  input  logic [rand_pkg::CNT3_W-1:0] dp_count,
  output logic                        dp_load,
  output logic                        dp_shift_en,
  output logic                        dp_xor_en,
  output logic [rand_pkg::LFSR_W-1:0] dp_data,
  output logic                        rnd_valid,
  output logic [rand_pkg::RES_W-1:0]  rnd_data,
  output logic                        busy,
  output logic                        done
);
  import rand_pkg::*;

  localparam logic [CNT3_W-1:0] STEP_INIT = CNT3_W'(DRAW_STEPS - 1);

  state_t            state, nxt;
  logic [LFSR_W-1:0] seed_q, seed_eff;
  logic              step_load, step_dec, step_zero;
  logic [CNT3_W-1:0] step_val, step_cnt;
  logic              draw_load, draw_dec, draw_last;
  logic [CNT_W-1:0]  draw_cnt;
  logic              hs, abort_hit;
  logic              unused_diag;

`ifdef RAND_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // dp_count is purely a diagnostic observation point for the checker
  assign unused_diag = ^dp_count;

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign hs       = (state == EMIT) && out_ready;
  assign dp_data  = dp_load ? seed_q : '0;
  assign rnd_data = rnd_valid ? dp_result : '0;

  rand_step_cnt #(.W(CNT3_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .load_val (step_val),
    .dec      (step_dec),
    .count    (step_cnt),
    .zero     (step_zero)
  );

  // Holds draws remaining minus one, so its zero flag marks the final draw.
  rand_step_cnt #(.W(CNT_W)) u_draw_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (draw_load),
    .load_val (num_draws - CNT_W'(1)),
    .dec      (draw_dec),
    .count    (draw_cnt),
    .zero     (draw_last)
  );

  always_comb begin
    nxt       = state;
    step_load = 1'b0;
    step_val  = '0;
    step_dec  = 1'b0;
    draw_load = 1'b0;
    draw_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_draws != '0) begin
            nxt       = LOAD;
            draw_load = 1'b1;
            step_load = 1'b1;
          end else begin
            nxt = DONE;
          end
        end
      end
      LOAD: begin
        nxt       = STEP;
        step_load = 1'b1;
        step_val  = STEP_INIT;
      end
      STEP: begin
        if (step_zero) nxt = EMIT;
        else           step_dec = 1'b1;
      end
      EMIT: begin
        if (hs) begin
          draw_dec = 1'b1;
          if (draw_last) begin
            nxt = DONE;
          end else begin
            nxt       = STEP;
            step_load = 1'b1;
            step_val  = STEP_INIT;
          end
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_hit && (state == LOAD || state == STEP || state == EMIT)) nxt = DONE;
  end

  // Outputs are registered from the next state so they are clean Moore decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      seed_q      <= '0;
      dp_load     <= 1'b0;
      dp_shift_en <= 1'b0;
      dp_xor_en   <= 1'b0;
      rnd_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt;
      if (draw_load) seed_q <= seed_eff;
      dp_load     <= (nxt == LOAD);
      dp_shift_en <= (nxt == STEP);
      dp_xor_en   <= (nxt == STEP);
      rnd_valid   <= (nxt == EMIT);
      busy        <= (nxt != IDLE);
      done        <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_rand_ctrl.sv
// Bench for rand_ctrl with a behavioural LFSR datapath and a draw/timing reference model.
module tb_rand_ctrl;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic [5:0] seed = '0;
  logic [7:0] num_draws = '0;
`ifdef RAND_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [1:0] dp_result;
  logic [2:0] dp_count;
  logic       dp_load, dp_shift_en, dp_xor_en;
  logic [5:0] dp_data;
  logic       rnd_valid;
  logic [1:0] rnd_data;
  logic       busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] lfsr_m;
  logic [2:0] cnt_m;

  always #5 clk = ~clk;

  rand_ctrl #(.DRAW_STEPS(DS), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .num_draws   (num_draws),
    .out_ready   (out_ready),
`ifdef RAND_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .dp_result   (dp_result),
    .dp_count    (dp_count),
    .dp_load     (dp_load),
    .dp_shift_en (dp_shift_en),
    .dp_xor_en   (dp_xor_en),
    .dp_data     (dp_data),
    .rnd_valid   (rnd_valid),
    .rnd_data    (rnd_data),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural datapath: x^6+x^5+1 LFSR, xor beats shift, counter cleared on load.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_m <= '0;
      cnt_m  <= '0;
    end else if (dp_load) begin
      lfsr_m <= dp_data;
      cnt_m  <= '0;
    end else if (dp_xor_en) begin
      lfsr_m <= {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[4]};
      cnt_m  <= cnt_m + 3'd1;
    end else if (dp_shift_en) begin
      lfsr_m <= {lfsr_m[4:0], 1'b0};
      cnt_m  <= cnt_m + 3'd1;
    end
  end
  assign dp_result = lfsr_m[5:4];
  assign dp_count  = cnt_m;

  // k-th draw (1-based) is the top two bits after k*DS xor-steps from the seed.
  function automatic logic [1:0] draw_val(input logic [5:0] s0, input int k);
    logic [5:0] s;
    s = s0;
    for (int i = 0; i < k * DS; i++) s = {s[4:0], s[5] ^ s[4]};
    return s[5:4];
  endfunction

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({dp_load, dp_shift_en, dp_xor_en, dp_data, rnd_valid, rnd_data, busy, done} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b required 0",
               {dp_load, dp_shift_en, dp_xor_en, dp_data, rnd_valid, rnd_data, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, rnd_valid, dp_load} !== 4'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset got %b required 0000", {busy, done, rnd_valid, dp_load});
    end
    @(posedge clk); #1;
  endtask

  // Fixed scenario with hand-derived values: seed 1, three draws, ready always high.
  task automatic test_known();
    logic       ov[1:12];
    logic [1:0] od[1:12];
    logic       odn[1:12];
    logic [2:0] cnt_end;
    seed = 6'd1; num_draws = 8'd3; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      ov[c] = rnd_valid; od[c] = rnd_data; odn[c] = done;
      cnt_end = dp_count;
      @(posedge clk); #1;
    end
    for (int c = 1; c <= 12; c++) begin
      n_cmp++;
      if (ov[c] !== (c == 4 || c == 7 || c == 10)) begin
        n_bad++;
        $display("FAIL known_valid cycle %0d got %b", c, ov[c]);
      end
      n_cmp++;
      if (odn[c] !== (c == 11)) begin
        n_bad++;
        $display("FAIL known_done cycle %0d got %b", c, odn[c]);
      end
    end
    n_cmp++;
    if ({od[4], od[7], od[10]} !== 6'b00_01_00) begin
      n_bad++;
      $display("FAIL known_data got %b %b %b required 00 01 00", od[4], od[7], od[10]);
    end
    n_cmp++;
    if (cnt_end !== 3'd6) begin
      n_bad++;
      $display("FAIL known_dp_count got %0d required 6", cnt_end);
    end
  endtask

  // Runs one sequence; ready is random at pct percent, forced low for `hold` cycles at the first draw.
  task automatic test_sequence(input logic [5:0] sd, input logic [7:0] n, input int pct,
                               input int hold, input string tag);
    logic [5:0] seed_eff;
    int acc, nv, done_cyc;
    bit finished;
    logic rdy, exp_valid, exp_done, exp_busy, exp_load, exp_step;
    seed_eff = (sd == 6'd0) ? 6'd1 : sd;
    acc = 0; nv = 2 + DS; done_cyc = (n == 8'd0) ? 1 : -1; finished = 0;
    seed = sd; num_draws = n; out_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 3000 && !finished; c++) begin
      rdy = ($urandom_range(0, 99) < pct) && (c >= 2 + DS + hold);
      out_ready = rdy;
      start = ($urandom_range(0, 3) == 0);
      seed = 6'($urandom);
      num_draws = 8'($urandom);
      @(negedge clk);
      exp_valid = (n != 8'd0) && (acc < int'(n)) && (c >= nv);
      exp_done  = (c == done_cyc);
      exp_busy  = (done_cyc < 0) || (c <= done_cyc);
      exp_load  = (n != 8'd0) && (c == 1);
      exp_step  = (n != 8'd0) && exp_busy && !exp_load && !exp_valid && !exp_done;
      n_cmp++;
      if (rnd_valid !== exp_valid) begin
        n_bad++; $display("FAIL %s valid c=%0d got %b required %b", tag, c, rnd_valid, exp_valid);
      end
      n_cmp++;
      if (done !== exp_done) begin
        n_bad++; $display("FAIL %s done c=%0d got %b required %b", tag, c, done, exp_done);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++; $display("FAIL %s busy c=%0d got %b required %b", tag, c, busy, exp_busy);
      end
      n_cmp++;
      if ({dp_load, dp_xor_en, dp_shift_en} !== {exp_load, exp_step, exp_step}) begin
        n_bad++;
        $display("FAIL %s dp_ctl c=%0d got %b required %b", tag, c,
                 {dp_load, dp_xor_en, dp_shift_en}, {exp_load, exp_step, exp_step});
      end
      if (exp_load) begin
        n_cmp++;
        if (dp_data !== seed_eff) begin
          n_bad++; $display("FAIL %s dp_data got %b required %b", tag, dp_data, seed_eff);
        end
      end
      if (exp_valid) begin
        n_cmp++;
        if (rnd_data !== draw_val(seed_eff, acc + 1)) begin
          n_bad++;
          $display("FAIL %s draw %0d got %b required %b", tag, acc + 1, rnd_data,
                   draw_val(seed_eff, acc + 1));
        end
        n_cmp++;
        if (dp_count !== 3'(((acc + 1) * DS) % 8)) begin
          n_bad++;
          $display("FAIL %s dp_count c=%0d got %0d required %0d", tag, c, dp_count,
                   ((acc + 1) * DS) % 8);
        end
        if (rdy) begin
          acc++;
          if (acc == int'(n)) done_cyc = c + 1;
          else nv = c + DS + 1;
        end
      end
      if (exp_done) finished = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++; $display("FAIL %s timeout got no done required done", tag);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++; $display("FAIL %s post_idle got %b required 00", tag, {busy, done});
    end
    if (n != 8'd0) begin
      n_cmp++;
      if (dp_count !== 3'((int'(n) * DS) % 8)) begin
        n_bad++;
        $display("FAIL %s end_dp_count got %0d required %0d", tag, dp_count, (int'(n) * DS) % 8);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    seed = 6'd1; num_draws = 8'd3; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (dp_xor_en !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset_pre got xor_en %b required 1", dp_xor_en);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({dp_load, dp_shift_en, dp_xor_en, dp_data, rnd_valid, rnd_data, busy, done} !== 14'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got %b required 0",
               {dp_load, dp_shift_en, dp_xor_en, dp_data, rnd_valid, rnd_data, busy, done});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, busy, rnd_valid} !== 3'b000) begin
        n_bad++; $display("FAIL mid_reset_idle c=%0d got %b required 000", c, {done, busy, rnd_valid});
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef RAND_CTRL_ABORT_EN
  task automatic test_abort();
    seed = 6'd5; num_draws = 8'd3; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy, rnd_valid, dp_xor_en} !== 4'b1100) begin
      n_bad++; $display("FAIL abort_done got %b required 1100", {done, busy, rnd_valid, dp_xor_en});
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, rnd_valid} !== 3'b000) begin
      n_bad++; $display("FAIL abort_idle got %b required 000", {done, busy, rnd_valid});
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_sequence(6'd1, 8'd3, 100, 0, "draw3");
    test_sequence(6'd0, 8'd1, 100, 0, "zero_seed");
    test_sequence(6'd9, 8'd4, 100, 5, "backpressure");
    test_sequence(6'd0, 8'd0, 100, 0, "zero_cnt");
    test_reset_mid();
    test_sequence(6'd33, 8'd2, 100, 0, "after_reset");
    for (int i = 0; i < 8; i++)
      test_sequence(6'($urandom), 8'($urandom_range(0, 12)), int'($urandom_range(30, 100)), 0, "random");
`ifdef RAND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rand_ctrl.md
Name: rand_ctrl

Overview:
- Control stage directly upstream of the random-number datapath.
- Drives the datapath's load/shift_en/xor_en/data_in, reads its result/shift_count_out, and emits a stream of 2-bit random draws over a valid/ready interface.
- One start request loads a seed, then produces NUM draws. Each draw advances the 6-bit LFSR by DRAW_STEPS xor-steps.

Parameters:
- DRAW_STEPS, 2, LFSR xor-steps per draw (1..7).
- CNT_W, 8, width of the draw-count input.
- DEFAULT_SEED, 6'b000001, seed substituted when the requested seed is 0, because the all-zero state locks up.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- seed  in  6  requested seed; captured with start.
- num_draws  in  CNT_W  number of draws; captured with start.
- out_ready  in  1  consumer ready.
- dp_result  in  2  datapath result (s[5:4]).
- dp_count  in  3  datapath shift_count_out.
- dp_load  out  1  datapath load.
- dp_shift_en  out  1  datapath shift_en.
- dp_xor_en  out  1  datapath xor_en.
- dp_data  out  6  datapath data_in.
- rnd_valid  out  1  draw available.
- rnd_data  out  2  draw value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; seed register=0; draws_left=0; step counter=0.
- FSM states: IDLE, LOAD, STEP, EMIT, DONE. Moore outputs only.
- IDLE
  - start=1 and num_draws!=0: capture seed, or DEFAULT_SEED if seed==0; draws_left=num_draws; go to LOAD.
  - start=1 and num_draws==0: go to DONE. No datapath activity.
- LOAD: dp_load=1, dp_data=captured seed, step counter cleared, then go to STEP. The datapath clears its own counter on load.
- STEP
  - dp_xor_en=1 and dp_shift_en=1 together: xor wins inside the datapath, and its counter increments.
  - Held for exactly DRAW_STEPS cycles, then go to EMIT.
- EMIT
  - rnd_valid=1, rnd_data=dp_result. All dp enables are 0, so the value is stable.
  - Handshake when rnd_valid and out_ready are both 1: draws_left decrements. If it reaches 0, go to DONE; else go to STEP.
  - Without out_ready, stay in EMIT indefinitely. rnd_data must not change.
- DONE: done=1 for one cycle, then go to IDLE. busy=0 from that IDLE cycle onward.
- Latency: with start sampled at edge 0, LOAD occupies cycle 1, STEP occupies cycles 2..1+DRAW_STEPS, and the first rnd_valid appears in cycle 2+DRAW_STEPS.
- With out_ready held at 1, each subsequent draw takes DRAW_STEPS+1 cycles.
- start while busy is ignored. Its seed and num_draws are not captured.
- dp_count is a diagnostic input only. It must equal (draws completed × DRAW_STEPS) mod 8; the checker compares against this.
- Reset asserted mid-sequence returns to IDLE immediately with rnd_valid=0. No done pulse.
- The dp_* outputs are never asserted together except the xor_en/shift_en pair.

Optional Feature:
- Macro: RAND_CTRL_ABORT_EN.
- Enabled: adds input abort (1 bit). abort=1 in LOAD, STEP or EMIT goes to DONE next cycle, so done pulses. rnd_valid drops the same cycle the state leaves EMIT. A handshake coinciding with abort still counts as accepted. abort is ignored in IDLE and DONE.
- Disabled: port absent; behaviour as above.

Decomposition:
- Package rand_pkg holds:
  - state enum: IDLE, LOAD, STEP, EMIT, DONE.
  - LFSR_W=6, RES_W=2, CNT3_W=3.
  - DEFAULT_SEED constant.
- One natural sub-module: rand_step_cnt, a loadable down-counter with zero flag used for both step and draw counting, instantiated twice.
- Top-level wrapper rand_top (rand_ctrl + datapath) for verification.

Test Plan:
- Draw sequence: seed=6'b000001, num_draws=3, DRAW_STEPS=2, out_ready=1 -> rnd_data 2'b00, 2'b01, 2'b00 at cycles 4, 7, 10; done at cycle 11; dp_count=6 at end.
- Zero seed: seed=0, num_draws=1 -> dp_data=6'b000001 during LOAD; rnd_data=2'b00.
- Backpressure: out_ready=0 for 5 cycles at the first EMIT -> rnd_valid held, rnd_data stable, dp enables 0, dp_count unchanged at 2.
- Zero count: num_draws=0, start -> no dp_load; done=1 at cycle 1; busy high for exactly 1 cycle.
- Reset and ignored start: rst low during the second STEP -> all outputs 0 that cycle, no done. Then start with busy=1 is ignored: draw count unaffected.
- Abort (RAND_CTRL_ABORT_EN only): abort in STEP -> DONE next cycle, done pulse, no rnd_valid.
